// File: rtl/dds_spi_sequencer.sv
// dds_spi_sequencer: four-frame AD9833 write sequencer
// with its own SCLK divider and MSB-first shift engine.
module dds_spi_sequencer #(
  parameter int CLK_DIV = 4,
  parameter int CS_GAP  = 2
) (
  input  logic        ACLK,
  input  logic        ARESETN,
  input  logic        start,
  input  logic [15:0] ctrl_word,
  input  logic [27:0] freq_word,
  input  logic [11:0] phase_word,
  input  logic        freq_sel,
  output logic        busy,
  output logic        done,
  output logic        sclk,
  output logic        mosi,
  output logic        fsync
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int GW = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(CS_GAP - 1);

  typedef enum logic [1:0] {
    IDLE,
    FRAME,
    GAP,
    FINISH
  } state_t;

  state_t        state_q;
  logic [DW-1:0] div_q;
  logic [GW-1:0] gap_q;
  logic [3:0]    bit_q;
  logic [1:0]    idx_q;
  logic [12:0]   ctrl_q;
  logic [27:0]   freq_q;
  logic [11:0]   phase_q;
  logic          sel_q;
  logic          busy_q;
  logic          done_q;
  logic          sclk_q;
  logic          mosi_q;
  logic          fsync_q;
  logic [15:0]   cur_word;
  logic [15:0]   nxt_word;
  logic          unused_ctrl;

  // B15/B14 are fixed and B28 is forced, so the top bits never matter
  assign unused_ctrl = ^ctrl_word[15:13];

  function automatic logic [15:0] frame_word(
    input logic [1:0]  idx,
    input logic [12:0] c,
    input logic [27:0] f,
    input logic [11:0] p,
    input logic        s
  );
    logic [1:0] a;
    a = s ? 2'b10 : 2'b01;
    case (idx)
      2'd0:    frame_word = {3'b001, c};
      2'd1:    frame_word = {a, f[13:0]};
      2'd2:    frame_word = {a, f[27:14]};
      default: frame_word = {3'b110, s, p};
    endcase
  endfunction

  // words for the frame in flight and the one after the gap
  always_comb begin
    cur_word = frame_word(idx_q, ctrl_q, freq_q, phase_q, sel_q);
    nxt_word = frame_word(idx_q + 2'd1, ctrl_q, freq_q, phase_q, sel_q);
  end

  // sequencer FSM, SCLK divider and shift engine
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q <= IDLE;
      div_q   <= '0;
      gap_q   <= '0;
      bit_q   <= '0;
      idx_q   <= '0;
      ctrl_q  <= '0;
      freq_q  <= '0;
      phase_q <= '0;
      sel_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sclk_q  <= 1'b1;
      mosi_q  <= 1'b0;
      fsync_q <= 1'b1;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            ctrl_q  <= ctrl_word[12:0];
            freq_q  <= freq_word;
            phase_q <= phase_word;
            sel_q   <= freq_sel;
            state_q <= FRAME;
            busy_q  <= 1'b1;
            fsync_q <= 1'b0;
            sclk_q  <= 1'b1;
            mosi_q  <= 1'b0;
            div_q   <= '0;
            bit_q   <= 4'd15;
            idx_q   <= 2'd0;
          end
        end
        FRAME: begin
          if (div_q == DIV_LAST) begin
            div_q <= '0;
            if (sclk_q) begin
              sclk_q <= 1'b0;
            end else if (bit_q == 4'd0) begin
              sclk_q  <= 1'b1;
              fsync_q <= 1'b1;
              mosi_q  <= 1'b0;
              gap_q   <= '0;
              if (idx_q == 2'd3) begin
                state_q <= FINISH;
                done_q  <= 1'b1;
              end else begin
                state_q <= GAP;
              end
            end else begin
              sclk_q <= 1'b1;
              bit_q  <= bit_q - 4'd1;
              mosi_q <= cur_word[bit_q - 4'd1];
            end
          end else begin
            div_q <= div_q + DW'(1);
          end
        end
        GAP: begin
          if (gap_q == GAP_LAST) begin
            state_q <= FRAME;
            idx_q   <= idx_q + 2'd1;
            fsync_q <= 1'b0;
            bit_q   <= 4'd15;
            div_q   <= '0;
            mosi_q  <= nxt_word[15];
          end else begin
            gap_q <= gap_q + GW'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign sclk  = sclk_q;
  assign mosi  = mosi_q;
  assign fsync = fsync_q;

endmodule

// File: tb/tb_dds_spi_sequencer.sv
// tb_dds_spi_sequencer: directed + random sequences on two
// configurations, SPI capture checked against a word model.
module tb_dds_spi_sequencer;

  localparam int CD0 = 4;
  localparam int CG0 = 2;
  localparam int CD1 = 1;
  localparam int CG1 = 1;

  logic        ACLK = 1'b0;
  logic        ARESETN = 1'b0;
  logic        start0 = 1'b0;
  logic        start1 = 1'b0;
  logic [15:0] ctrl_word = '0;
  logic [27:0] freq_word = '0;
  logic [11:0] phase_word = '0;
  logic        freq_sel = 1'b0;
  logic [1:0]  busy_m, done_m, sclk_m, mosi_m, fsync_m;

  int n_assert = 0;
  int n_fail = 0;

  always #5 ACLK = ~ACLK;

  dds_spi_sequencer #(.CLK_DIV(CD0), .CS_GAP(CG0)) u_dut (
    .ACLK(ACLK), .ARESETN(ARESETN), .start(start0),
    .ctrl_word(ctrl_word), .freq_word(freq_word),
    .phase_word(phase_word), .freq_sel(freq_sel),
    .busy(busy_m[0]), .done(done_m[0]), .sclk(sclk_m[0]),
    .mosi(mosi_m[0]), .fsync(fsync_m[0])
  );

  dds_spi_sequencer #(.CLK_DIV(CD1), .CS_GAP(CG1)) u_fast (
    .ACLK(ACLK), .ARESETN(ARESETN), .start(start1),
    .ctrl_word(ctrl_word), .freq_word(freq_word),
    .phase_word(phase_word), .freq_sel(freq_sel),
    .busy(busy_m[1]), .done(done_m[1]), .sclk(sclk_m[1]),
    .mosi(mosi_m[1]), .fsync(fsync_m[1])
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic int low_w(input int i);
    return (i == 0) ? 32 * CD0 : 32 * CD1;
  endfunction

  function automatic int gap_w(input int i);
    return (i == 0) ? CG0 : CG1;
  endfunction

  function automatic int total_w(input int i);
    return (i == 0) ? 128 * CD0 + 3 * CG0 + 1 : 128 * CD1 + 3 * CG1 + 1;
  endfunction

  // reference: each frame from the register-map rules
  function automatic logic [15:0] model_frame(input int n,
    input logic [15:0] c, input logic [27:0] f,
    input logic [11:0] p, input logic s);
    int a;
    int v;
    a = s ? 2 : 1;
    case (n)
      0: v = 'h2000 + int'(c % 16'h2000);
      1: v = a * 16384 + int'(f % 28'd16384);
      2: v = a * 16384 + int'(f / 28'd16384);
      default: v = 'hC000 + int'(s) * 4096 + int'(p);
    endcase
    return v[15:0];
  endfunction

  // SPI monitor state, one slot per instance
  logic [15:0] cap0[$];
  logic [15:0] cap1[$];
  logic [15:0] sh[2];
  int lowc[2], hic[2], bits[2], nfr[2], ndone[2];
  logic ps[2], pf[2], pm[2];

  initial begin
    for (int i = 0; i < 2; i++) begin
      sh[i] = '0; lowc[i] = 0; hic[i] = 0; bits[i] = 0;
      nfr[i] = 0; ndone[i] = 0;
      ps[i] = 1'b1; pf[i] = 1'b1; pm[i] = 1'b0;
    end
  end

  // capture frames on falling SCLK and check frame/gap timing
  always @(negedge ACLK) begin
    for (int i = 0; i < 2; i++) begin
      if (!ARESETN) begin
        bits[i] = 0; lowc[i] = 0; hic[i] = 0; nfr[i] = 0;
        if (i == 0) cap0.delete(); else cap1.delete();
      end else begin
        if (mosi_m[i] !== pm[i])
          chk($sformatf("mosi_stable%0d", i), sclk_m[i], 1'b1);
        if (fsync_m[i] !== pf[i])
          chk($sformatf("sclk_at_fsync%0d", i), sclk_m[i], 1'b1);
        if (fsync_m[i] == 1'b0) begin
          if (pf[i]) begin
            if (nfr[i] > 0)
              chk($sformatf("gap_width%0d", i), hic[i], gap_w(i));
            lowc[i] = 1; bits[i] = 0; sh[i] = '0;
          end else begin
            lowc[i]++;
          end
          if (ps[i] && !sclk_m[i]) begin
            sh[i] = {sh[i][14:0], mosi_m[i]};
            bits[i]++;
          end
        end else begin
          if (!pf[i]) begin
            chk($sformatf("low_width%0d", i), lowc[i], low_w(i));
            chk($sformatf("bit_count%0d", i), bits[i], 16);
            if (i == 0) cap0.push_back(sh[i]);
            else cap1.push_back(sh[i]);
            nfr[i]++;
            hic[i] = 1;
          end else begin
            hic[i]++;
          end
        end
        if (done_m[i]) begin
          ndone[i]++;
          nfr[i] = 0;
        end
      end
      ps[i] = sclk_m[i]; pf[i] = fsync_m[i]; pm[i] = mosi_m[i];
    end
  end

  // one sequence: start at this negedge, optional disturbance/reset
  task automatic run_seq(input int inst, input logic [15:0] c,
    input logic [27:0] f, input logic [11:0] p, input logic s,
    input bit disturb, input int rst_at);
    int base, k, busy_low, sz;
    bit seen;
    logic [15:0] got;
    ctrl_word = c; freq_word = f; phase_word = p; freq_sel = s;
    if (inst == 0) cap0.delete(); else cap1.delete();
    base = ndone[inst];
    busy_low = 0;
    seen = 1'b0;
    if (inst == 0) start0 = 1'b1; else start1 = 1'b1;
    @(negedge ACLK);
    start0 = 1'b0; start1 = 1'b0;
    k = 1;
    chk("c1_busy", busy_m[inst], 1'b1);
    chk("c1_fsync", fsync_m[inst], 1'b0);
    chk("c1_sclk", sclk_m[inst], 1'b1);
    chk("c1_mosi", mosi_m[inst], model_frame(0, c, f, p, s) >> 15);
    while (!seen && k < 2000) begin
      if (rst_at != 0 && k == rst_at) begin
        ARESETN = 1'b0;
        #1;
        chk("rst_sclk", sclk_m[inst], 1'b1);
        chk("rst_fsync", fsync_m[inst], 1'b1);
        chk("rst_mosi", mosi_m[inst], 1'b0);
        chk("rst_busy", busy_m[inst], 1'b0);
        chk("rst_done", done_m[inst], 1'b0);
        repeat (3) @(negedge ACLK);
        chk("rst_no_done", ndone[inst] - base, 0);
        ARESETN = 1'b1;
        return;
      end
      if (done_m[inst]) begin
        seen = 1'b1;
      end else begin
        if (!busy_m[inst]) busy_low++;
        if (disturb && k == 5) freq_word = 28'hFFFFFFF;
        if (inst == 0) start0 = disturb && (k == 10 || k == 300);
        @(negedge ACLK);
        start0 = 1'b0;
        k++;
      end
    end
    chk("done_seen", seen, 1'b1);
    chk("done_cycle", k, total_w(inst));
    chk("busy_at_done", busy_m[inst], 1'b1);
    chk("busy_continuous", busy_low, 0);
    @(negedge ACLK);
    chk("idle_busy", busy_m[inst], 1'b0);
    chk("idle_done", done_m[inst], 1'b0);
    chk("done_once", ndone[inst] - base, 1);
    sz = (inst == 0) ? cap0.size() : cap1.size();
    chk("frame_count", sz, 4);
    for (int n = 0; n < 4; n++) begin
      if (n < sz) begin
        got = (inst == 0) ? cap0[n] : cap1[n];
        chk($sformatf("frame%0d", n), got, model_frame(n, c, f, p, s));
      end
    end
  endtask

  initial begin
    logic [15:0] rc;
    logic [27:0] rf;
    logic [11:0] rp;
    logic rs;
    repeat (3) @(negedge ACLK);
    chk("reset_busy", busy_m[0], 1'b0);
    chk("reset_done", done_m[0], 1'b0);
    chk("reset_sclk", sclk_m[0], 1'b1);
    chk("reset_mosi", mosi_m[0], 1'b0);
    chk("reset_fsync", fsync_m[0], 1'b1);
    ARESETN = 1'b1;
    @(negedge ACLK);

    run_seq(0, 16'h0000, 28'h0ABCDEF, 12'h123, 1'b0, 1'b0, 0);
    run_seq(0, 16'h0000, 28'h0ABCDEF, 12'h123, 1'b1, 1'b0, 0);
    run_seq(0, 16'h0000, 28'h0ABCDEF, 12'h123, 1'b0, 1'b1, 0);
    repeat (3) @(negedge ACLK);

    rc = 16'($urandom); rf = 28'($urandom); rp = 12'($urandom);
    run_seq(0, rc, rf, rp, 1'b1, 1'b0, 150);
    run_seq(0, 16'hFFFF, 28'h0ABCDEF, 12'h123, 1'b0, 1'b0, 0);

    for (int t = 0; t < 3; t++) begin
      rc = 16'($urandom); rf = 28'($urandom);
      rp = 12'($urandom); rs = 1'($urandom);
      run_seq(0, rc, rf, rp, rs, 1'b0, 0);
      repeat ($urandom_range(0, 4)) @(negedge ACLK);
    end

    run_seq(1, 16'h0000, 28'h0ABCDEF, 12'h123, 1'b0, 1'b0, 0);
    for (int t = 0; t < 2; t++) begin
      rc = 16'($urandom); rf = 28'($urandom);
      rp = 12'($urandom); rs = 1'($urandom);
      run_seq(1, rc, rf, rp, rs, 1'b0, 0);
    end
    repeat (5) @(negedge ACLK);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
